// File: rtl/blob_centroid_tracker.sv
// blob_centroid_tracker
//
// Multi-channel colour-blob centroid tracker in the VGA pixel stream. For each of NUM_CH
// RGB threshold windows it accumulates the X/Y sums and the count of matching pixels over
// a frame. At each frame end the totals go to shadow registers, and a shared restoring
// divider computes per-channel centroids. The results are published together with a
// one-cycle RESULT_VALID strobe.
//
// Optional feature: define BLOB_OVERLAY_EN to draw a magenta crosshair at every published
// centroid with FOUND=1. Without it, the RGB outputs are a plain 2-cycle delay.
//
// Ports:
//   CLK, RST             pixel clock, asynchronous active-high reset
//   ENABLE               accumulation enable
//   DE, VS               pixel valid, vertical sync (active low)
//   X, Y                 pixel coordinates
//   R_IN, G_IN, B_IN     pixel colour
//   THR_LO, THR_HI       per-channel inclusive {R,G,B} bounds, channel i at [24i+23:24i]
//   MIN_PIX              minimum matched-pixel count for FOUND
//   CX, CY               per-channel centroids
//   PIX_COUNT            per-channel matched pixels in the last published frame
//   FOUND                per-channel blob present
//   RESULT_VALID         one-cycle strobe while new results are presented
//   OVERRUN              one-cycle strobe when a frame end arrived while dividing
//   R_OUT, G_OUT, B_OUT  pixel stream delayed by 2 cycles
module blob_centroid_tracker #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 13,
  parameter int unsigned PIX_W  = 20
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic                    DE,
  input  logic                    VS,
  input  logic [CNT_W-1:0]        X,
  input  logic [CNT_W-1:0]        Y,
  input  logic [7:0]              R_IN,
  input  logic [7:0]              G_IN,
  input  logic [7:0]              B_IN,
  input  logic [NUM_CH*24-1:0]    THR_LO,
  input  logic [NUM_CH*24-1:0]    THR_HI,
  input  logic [PIX_W-1:0]        MIN_PIX,
  output logic [NUM_CH*CNT_W-1:0] CX,
  output logic [NUM_CH*CNT_W-1:0] CY,
  output logic [NUM_CH*PIX_W-1:0] PIX_COUNT,
  output logic [NUM_CH-1:0]       FOUND,
  output logic                    RESULT_VALID,
  output logic                    OVERRUN,
  output logic [7:0]              R_OUT,
  output logic [7:0]              G_OUT,
  output logic [7:0]              B_OUT
);

  localparam int unsigned SUM_W = CNT_W + PIX_W;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STP_W = $clog2(CNT_W + 1);
  localparam logic [CH_W-1:0]  LastCh   = CH_W'(NUM_CH - 1);
  localparam logic [STP_W-1:0] LastStep = STP_W'(CNT_W);

  typedef enum logic [1:0] {
    StWaitFrame,
    StAccum,
    StDiv,
    StUpdate
  } state_t;

  state_t r_state, w_state_nxt;

  // ---------------------------------------------------------------------------------------
  // Stage 1: register the pixel and its per-channel window match
  // ---------------------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_match_in;
  logic [NUM_CH-1:0] r_s1_match;
  logic              r_s1_vs;
  logic [CNT_W-1:0]  r_s1_x;
  logic [CNT_W-1:0]  r_s1_y;
  logic [7:0]        r_s1_r;
  logic [7:0]        r_s1_g;
  logic [7:0]        r_s1_b;

  always_comb begin
    w_match_in = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_match_in[i] = DE && ENABLE &&
                      (R_IN >= THR_LO[24*i+16 +: 8]) && (R_IN <= THR_HI[24*i+16 +: 8]) &&
                      (G_IN >= THR_LO[24*i+8  +: 8]) && (G_IN <= THR_HI[24*i+8  +: 8]) &&
                      (B_IN >= THR_LO[24*i    +: 8]) && (B_IN <= THR_HI[24*i    +: 8]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_match <= '0;
      r_s1_vs    <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_match <= w_match_in;
      r_s1_vs    <= VS;
      r_s1_x     <= X;
      r_s1_y     <= Y;
      r_s1_r     <= R_IN;
      r_s1_g     <= G_IN;
      r_s1_b     <= B_IN;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 2: frame-end detection, pixel output, accumulation
  // ---------------------------------------------------------------------------------------
  logic       r_s2_vs;
  logic [7:0] r_s2_r;
  logic [7:0] r_s2_g;
  logic [7:0] r_s2_b;
  logic       w_frame_end;
  logic       w_cross;

  // Falling VS between stage 1 and stage 2 keeps the frame boundary aligned with the pixel
  // currently entering accumulation.
  assign w_frame_end = r_s2_vs && !r_s1_vs;

  // Published results (declared here because the overlay reads them)
  logic [CNT_W-1:0]  r_cx    [NUM_CH];
  logic [CNT_W-1:0]  r_cy    [NUM_CH];
  logic [PIX_W-1:0]  r_pix   [NUM_CH];
  logic [NUM_CH-1:0] r_found;

`ifdef BLOB_OVERLAY_EN
  always_comb begin
    w_cross = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_found[i] && ((r_s1_x == r_cx[i]) || (r_s1_y == r_cy[i]))) begin
        w_cross = 1'b1;
      end
    end
  end
`else
  assign w_cross = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s2_vs <= 1'b0;
      r_s2_r  <= '0;
      r_s2_g  <= '0;
      r_s2_b  <= '0;
    end else begin
      r_s2_vs <= r_s1_vs;
      r_s2_r  <= w_cross ? 8'hFF : r_s1_r;
      r_s2_g  <= w_cross ? 8'h00 : r_s1_g;
      r_s2_b  <= w_cross ? 8'hFF : r_s1_b;
    end
  end

  assign R_OUT = r_s2_r;
  assign G_OUT = r_s2_g;
  assign B_OUT = r_s2_b;

  logic [PIX_W-1:0] r_acc_cnt [NUM_CH];
  logic [SUM_W-1:0] r_acc_sx  [NUM_CH];
  logic [SUM_W-1:0] r_acc_sy  [NUM_CH];

  // Every frame end clears the accumulators, including one that is dropped as an overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc_cnt[i] <= '0;
        r_acc_sx[i]  <= '0;
        r_acc_sy[i]  <= '0;
      end
    end else if (w_frame_end || (r_state == StWaitFrame)) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc_cnt[i] <= '0;
        r_acc_sx[i]  <= '0;
        r_acc_sy[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // A saturated count freezes the sums too, so the quotient stays below 2^CNT_W.
        if (r_s1_match[i] && (r_acc_cnt[i] != '1)) begin
          r_acc_cnt[i] <= r_acc_cnt[i] + PIX_W'(1);
          r_acc_sx[i]  <= r_acc_sx[i] + {{PIX_W{1'b0}}, r_s1_x};
          r_acc_sy[i]  <= r_acc_sy[i] + {{PIX_W{1'b0}}, r_s1_y};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Shadow snapshot
  // ---------------------------------------------------------------------------------------
  logic [PIX_W-1:0] r_sh_cnt [NUM_CH];
  logic [SUM_W-1:0] r_sh_sx  [NUM_CH];
  logic [SUM_W-1:0] r_sh_sy  [NUM_CH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_sh_cnt[i] <= '0;
        r_sh_sx[i]  <= '0;
        r_sh_sy[i]  <= '0;
      end
    end else if (w_frame_end && (r_state == StAccum)) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_sh_cnt[i] <= r_acc_cnt[i];
        r_sh_sx[i]  <= r_acc_sx[i];
        r_sh_sy[i]  <= r_acc_sy[i];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Shared restoring divider: step 0 loads, steps 1..CNT_W each retire one quotient bit.
  // The remainder starts with the upper PIX_W bits of the sum. This is valid because
  // sum <= count * (2^CNT_W - 1), which also guarantees that the quotient fits in CNT_W
  // bits. Quotient bits shift into the vacated low end of the dividend register.
  // ---------------------------------------------------------------------------------------
  logic [CH_W-1:0]  r_ch;
  logic [STP_W-1:0] r_step;
  logic [PIX_W-1:0] r_remx;
  logic [PIX_W-1:0] r_remy;
  logic [CNT_W-1:0] r_dvx;
  logic [CNT_W-1:0] r_dvy;
  logic [CNT_W-1:0] r_qx [NUM_CH];
  logic [CNT_W-1:0] r_qy [NUM_CH];

  logic [SUM_W-1:0] w_sx;
  logic [SUM_W-1:0] w_sy;
  logic [PIX_W-1:0] w_div;
  logic [PIX_W:0]   w_tx;
  logic [PIX_W:0]   w_ty;
  logic             w_gex;
  logic             w_gey;
  logic [PIX_W-1:0] w_remx_nxt;
  logic [PIX_W-1:0] w_remy_nxt;
  logic [CNT_W-1:0] w_qx_nxt;
  logic [CNT_W-1:0] w_qy_nxt;
  logic             w_last_step;
  logic             w_div_done;

  assign w_sx  = r_sh_sx[r_ch];
  assign w_sy  = r_sh_sy[r_ch];
  assign w_div = r_sh_cnt[r_ch];

  assign w_tx       = {r_remx, r_dvx[CNT_W-1]};
  assign w_ty       = {r_remy, r_dvy[CNT_W-1]};
  assign w_gex      = (w_tx >= {1'b0, w_div});
  assign w_gey      = (w_ty >= {1'b0, w_div});
  assign w_remx_nxt = w_gex ? PIX_W'(w_tx - {1'b0, w_div}) : w_tx[PIX_W-1:0];
  assign w_remy_nxt = w_gey ? PIX_W'(w_ty - {1'b0, w_div}) : w_ty[PIX_W-1:0];
  assign w_qx_nxt   = {r_dvx[CNT_W-2:0], w_gex};
  assign w_qy_nxt   = {r_dvy[CNT_W-2:0], w_gey};

  assign w_last_step = (r_state == StDiv) && (r_step == LastStep);
  assign w_div_done  = w_last_step && (r_ch == LastCh);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ch   <= '0;
      r_step <= '0;
      r_remx <= '0;
      r_remy <= '0;
      r_dvx  <= '0;
      r_dvy  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_qx[i] <= '0;
        r_qy[i] <= '0;
      end
    end else if ((r_state == StAccum) && w_frame_end) begin
      r_ch   <= '0;
      r_step <= '0;
    end else if (r_state == StDiv) begin
      if (r_step == '0) begin
        r_remx <= w_sx[SUM_W-1:CNT_W];
        r_remy <= w_sy[SUM_W-1:CNT_W];
        r_dvx  <= w_sx[CNT_W-1:0];
        r_dvy  <= w_sy[CNT_W-1:0];
      end else begin
        r_remx <= w_remx_nxt;
        r_remy <= w_remy_nxt;
        r_dvx  <= w_qx_nxt;
        r_dvy  <= w_qy_nxt;
      end
      if (w_last_step) begin
        r_step <= '0;
        if (r_ch != LastCh) begin
          r_ch <= r_ch + CH_W'(1);
        end
        // A zero count would produce a meaningless quotient, so it is not stored.
        if (w_div != '0) begin
          r_qx[r_ch] <= w_qx_nxt;
          r_qy[r_ch] <= w_qy_nxt;
        end
      end else begin
        r_step <= r_step + STP_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Result registers: loaded on the edge that enters StUpdate, so the values are already
  // present while RESULT_VALID is high. The last channel's quotient is taken straight from
  // the divider because it completes on that same edge.
  // ---------------------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_found;

  always_comb begin
    w_found = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_found[i] = (r_sh_cnt[i] != '0) && (r_sh_cnt[i] >= MIN_PIX);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_found <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_cx[i]  <= '0;
        r_cy[i]  <= '0;
        r_pix[i] <= '0;
      end
    end else if (w_div_done) begin
      r_found <= w_found;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_pix[i] <= r_sh_cnt[i];
        if (w_found[i]) begin
          r_cx[i] <= (i == NUM_CH - 1) ? w_qx_nxt : r_qx[i];
          r_cy[i] <= (i == NUM_CH - 1) ? w_qy_nxt : r_qy[i];
        end
      end
    end
  end

  logic r_overrun;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_frame_end && ((r_state == StDiv) || (r_state == StUpdate));
    end
  end

  assign OVERRUN = r_overrun;
  assign FOUND   = r_found;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign CX[g*CNT_W +: CNT_W]        = r_cx[g];
    assign CY[g*CNT_W +: CNT_W]        = r_cy[g];
    assign PIX_COUNT[g*PIX_W +: PIX_W] = r_pix[g];
  end

  // ---------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StWaitFrame;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    RESULT_VALID = 1'b0;
    unique case (r_state)
      StWaitFrame: begin
        // The first frame end after reset only marks the start of a full frame.
        if (w_frame_end) w_state_nxt = StAccum;
      end
      StAccum: begin
        if (w_frame_end) w_state_nxt = StDiv;
      end
      StDiv: begin
        if (w_div_done) w_state_nxt = StUpdate;
      end
      StUpdate: begin
        RESULT_VALID = 1'b1;
        w_state_nxt  = StAccum;
      end
      default: w_state_nxt = StWaitFrame;
    endcase
  end

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Directed testbench for blob_centroid_tracker (default parameters, default build).
module tb_blob_centroid_tracker;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 13;
  localparam int PIX_W  = 20;

  // Pixel colours against ch0 {C8..FF, 00..3F, 00..3F} and ch1 {80..FF, 00..FF, 00..1F}
  localparam logic [23:0] C_EDGE = 24'hC8_3F_00;  // on ch0 bounds, inside ch1
  localparam logic [23:0] C_RED  = 24'hFF_00_3F;  // on ch0 bounds, outside ch1 (B)
  localparam logic [23:0] C_BOTH = 24'hD0_20_10;  // inside both

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    de;
  logic                    vs;
  logic [CNT_W-1:0]        xi;
  logic [CNT_W-1:0]        yi;
  logic [7:0]              r_in;
  logic [7:0]              g_in;
  logic [7:0]              b_in;
  logic [NUM_CH*24-1:0]    thr_lo;
  logic [NUM_CH*24-1:0]    thr_hi;
  logic [PIX_W-1:0]        min_pix;
  logic [NUM_CH*CNT_W-1:0] cx;
  logic [NUM_CH*CNT_W-1:0] cy;
  logic [NUM_CH*PIX_W-1:0] pix_count;
  logic [NUM_CH-1:0]       found;
  logic                    result_valid;
  logic                    overrun;
  logic [7:0]              r_out;
  logic [7:0]              g_out;
  logic [7:0]              b_out;

  blob_centroid_tracker #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .PIX_W (PIX_W)
  ) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .ENABLE      (enable),
    .DE          (de),
    .VS          (vs),
    .X           (xi),
    .Y           (yi),
    .R_IN        (r_in),
    .G_IN        (g_in),
    .B_IN        (b_in),
    .THR_LO      (thr_lo),
    .THR_HI      (thr_hi),
    .MIN_PIX     (min_pix),
    .CX          (cx),
    .CY          (cy),
    .PIX_COUNT   (pix_count),
    .FOUND       (found),
    .RESULT_VALID(result_valid),
    .OVERRUN     (overrun),
    .R_OUT       (r_out),
    .G_OUT       (g_out),
    .B_OUT       (b_out)
  );

  always #5 clk = ~clk;

  logic [CNT_W-1:0] cx0, cy0, cx1, cy1;
  logic [PIX_W-1:0] pix0, pix1;
  assign cx0  = cx[CNT_W-1:0];
  assign cx1  = cx[2*CNT_W-1:CNT_W];
  assign cy0  = cy[CNT_W-1:0];
  assign cy1  = cy[2*CNT_W-1:CNT_W];
  assign pix0 = pix_count[PIX_W-1:0];
  assign pix1 = pix_count[2*PIX_W-1:PIX_W];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input int x, input int y, input logic [23:0] rgb);
    @(negedge clk);
    de = 1'b1;
    xi = CNT_W'(x);
    yi = CNT_W'(y);
    {r_in, g_in, b_in} = rgb;
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
      {r_in, g_in, b_in} = 24'h0;
    end
  endtask

  // Pixels just outside the windows: ch0 R low / G high / B high, each also failing ch1 B.
  task automatic nonmatch();
    px(99, 50, 24'hC7_00_3F);
    px(110, 50, 24'hFF_40_3F);
    px(5, 5, 24'hFF_00_40);
    blank(1);
  endtask

  // 10x10 square at X 100..109, Y 50..59. (x+y) even uses C_EDGE, so ch1 sees 50 pixels.
  task automatic square();
    for (int y = 50; y <= 59; y++) begin
      for (int x = 100; x <= 109; x++) begin
        px(x, y, (((x + y) % 2) == 0) ? C_EDGE : C_RED);
      end
    end
    nonmatch();
  endtask

  // Drop VS and watch 60 cycles. lat counts negedges after the VS drop: VS is sampled on the
  // next edge, which starts cycle E, so UPDATE at E+29 is seen on negedge 30. With inject,
  // a matching pixel is sent during DIV and a second VS fall lands at E+10.
  task automatic frame_end(input bit inject, output int lat, output int nvalid,
                           output int novr);
    lat    = 0;
    nvalid = 0;
    novr   = 0;
    @(negedge clk);
    de = 1'b0;
    vs = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (result_valid) begin
        nvalid++;
        if (lat == 0) lat = n;
      end
      if (overrun) novr++;
      if (n == 2) vs = 1'b1;
      if (inject && (n == 3)) begin
        de = 1'b1;
        xi = CNT_W'(7);
        yi = CNT_W'(9);
        {r_in, g_in, b_in} = C_BOTH;
      end
      if (n == 4) de = 1'b0;
      if (inject && (n == 10)) vs = 1'b0;
      if (inject && (n == 12)) vs = 1'b1;
    end
  endtask

  int lat, nv, no;
  logic [7:0] sent_r [8];

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    de      = 1'b0;
    vs      = 1'b1;
    xi      = '0;
    yi      = '0;
    r_in    = 8'h00;
    g_in    = 8'h00;
    b_in    = 8'h00;
    thr_lo  = {24'h80_00_00, 24'hC8_00_00};
    thr_hi  = {24'hFF_FF_1F, 24'hFF_3F_3F};
    min_pix = PIX_W'(1);
    repeat (3) @(negedge clk);

    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_pix", pix_count, 0);
    check("rst_found", found, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rgb", {r_out, g_out, b_out}, 0);
    rst = 1'b0;

    // 2-cycle pixel delay with DE low
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) check("delay_r", r_out, sent_r[i-2]);
      if (i == 4) check("delay_gb", {g_out, b_out}, {8'h5A ^ sent_r[2], ~sent_r[2]});
      sent_r[i] = 8'h31 + 8'(i * 17);
      r_in = sent_r[i];
      g_in = 8'h5A ^ sent_r[i];
      b_in = ~sent_r[i];
    end
    blank(2);

    // First frame end after reset is discarded
    square();
    frame_end(1'b0, lat, nv, no);
    check("first_discard_valid", nv, 0);

    // Full square frame
    square();
    frame_end(1'b0, lat, nv, no);
    check("sq_latency", lat, 30);
    check("sq_nvalid", nv, 1);
    check("sq_overrun", no, 0);
    check("sq_pix0", pix0, 100);
    check("sq_cx0", cx0, 104);
    check("sq_cy0", cy0, 54);
    check("sq_pix1", pix1, 50);
    check("sq_cx1", cx1, 104);
    check("sq_cy1", cy1, 54);
    check("sq_found", found, 2'b11);

    // No matching pixels: counts zero, centroids held
    nonmatch();
    frame_end(1'b0, lat, nv, no);
    check("empty_nvalid", nv, 1);
    check("empty_pix", pix_count, 0);
    check("empty_found", found, 0);
    check("empty_cx0", cx0, 104);
    check("empty_cy0", cy0, 54);

    // Single pixel inside both windows
    nonmatch();
    px(7, 9, C_BOTH);
    blank(1);
    frame_end(1'b0, lat, nv, no);
    check("pt_pix0", pix0, 1);
    check("pt_pix1", pix1, 1);
    check("pt_cx", {cx1, cx0}, {CNT_W'(7), CNT_W'(7)});
    check("pt_cy", {cy1, cy0}, {CNT_W'(9), CNT_W'(9)});
    check("pt_found", found, 2'b11);

    // ENABLE low: nothing accumulates
    enable = 1'b0;
    square();
    frame_end(1'b0, lat, nv, no);
    enable = 1'b1;
    check("dis_pix0", pix0, 0);
    check("dis_found", found, 0);
    check("dis_cx0", cx0, 7);

    // MIN_PIX above the count: FOUND low, count published, centroids held
    min_pix = PIX_W'(101);
    square();
    frame_end(1'b0, lat, nv, no);
    check("min_pix0", pix0, 100);
    check("min_pix1", pix1, 50);
    check("min_found", found, 0);
    check("min_cx0", cx0, 7);
    check("min_cy0", cy0, 9);
    check("min_cx1", cx1, 7);
    min_pix = PIX_W'(1);

    // Second frame end during DIV
    square();
    frame_end(1'b1, lat, nv, no);
    check("ovr_latency", lat, 30);
    check("ovr_nvalid", nv, 1);
    check("ovr_count", no, 1);
    check("ovr_pix0", pix0, 100);
    check("ovr_cx0", cx0, 104);
    check("ovr_cy0", cy0, 54);
    // Next frame holds only the square: the pixel sent in the dropped frame is gone
    square();
    frame_end(1'b0, lat, nv, no);
    check("post_ovr_nvalid", nv, 1);
    check("post_ovr_pix0", pix0, 100);
    check("post_ovr_pix1", pix1, 50);

    // Reset in the middle of a frame
    for (int i = 0; i < 20; i++) px(100 + (i % 10), 50 + (i / 10), C_RED);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cx", cx, 0);
    check("mid_rst_pix", pix_count, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_rgb", {r_out, g_out, b_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    de  = 1'b0;
    square();
    frame_end(1'b0, lat, nv, no);
    check("rst_discard_nvalid", nv, 0);
    square();
    frame_end(1'b0, lat, nv, no);
    check("rst_next_latency", lat, 30);
    check("rst_next_pix0", pix0, 100);
    check("rst_next_cx0", cx0, 104);
    check("rst_next_cy0", cy0, 54);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
